// File: rtl/debounce_multi_btn.sv
// debounce_multi_btn: N-channel synchroniser/debouncer with press/release strobes and
// modulo press counters. Define LONG_PRESS_EN to add per-channel long-press strobes.
module debounce_multi_btn #(
    parameter int N_BTN       = 4,
    parameter int DEB_CYCLES  = 65536,
    parameter int CNT_WIDTH   = 4,
    parameter int CNT_MOD     = 9,
    parameter int ACTIVE_LOW  = 0,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_BTN-1:0]           btn_in,
    input  logic                       cnt_clr,
    output logic [N_BTN-1:0]           btn_level,
    output logic [N_BTN-1:0]           press_pulse,
    output logic [N_BTN-1:0]           release_pulse,
    output logic [N_BTN*CNT_WIDTH-1:0] press_cnt,
    output logic                       any_press,
    output logic [N_BTN-1:0]           long_pulse
);

    localparam int STAB_W = $clog2(DEB_CYCLES);
    localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(DEB_CYCLES - 1);
    localparam logic [STAB_W-1:0]    STAB_ONE = STAB_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CNT_MOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic                 INVERT   = (ACTIVE_LOW != 0);

    localparam bit PARAMS_OK = (N_BTN >= 1) && (DEB_CYCLES >= 2) && (CNT_MOD >= 2)
                               && (CNT_MOD <= (2 ** CNT_WIDTH)) && (LONG_CYCLES >= 1);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("debounce_multi_btn: illegal parameter combination");
        end
    endgenerate

    assign any_press = |press_pulse;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic                 pin_raw;
        logic                 s1_q, s1_d;
        logic                 s2_q, s2_d;
        logic                 cand_q, cand_d;
        logic [STAB_W-1:0]    stab_q, stab_d;
        logic                 level_q, level_d;
        logic                 press_q, press_d;
        logic                 rel_q, rel_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 stab_sat;

        assign pin_raw  = btn_in[gi] ^ INVERT;
        assign stab_sat = (stab_q == STAB_MAX);

        always_comb begin : sync_next
            s1_d = pin_raw;
            s2_d = s1_q;
        end

        // A new level is only accepted once the candidate has been stable long
        // enough; any disagreement restarts the stability count from zero.
        always_comb begin : debounce_next
            cand_d  = cand_q;
            stab_d  = stab_q;
            level_d = level_q;
            if (s2_q != cand_q) begin
                cand_d = s2_q;
                stab_d = '0;
            end else if (!stab_sat) begin
                stab_d = stab_q + STAB_ONE;
            end else if (level_q != cand_q) begin
                level_d = cand_q;
            end
        end

        always_comb begin : strobe_next
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (level_d != level_q) begin
                press_d = level_d;
                rel_d   = ~level_d;
            end
        end

        // Clear wins over a press arriving on the same edge.
        always_comb begin : counter_next
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (press_d) begin
                cnt_d = (cnt_q == CNT_MAX) ? '0 : (cnt_q + CNT_ONE);
            end
        end

        always_ff @(posedge clk or negedge reset) begin : sync_regs
            if (!reset) begin
                s1_q <= 1'b0;
                s2_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end

        always_ff @(posedge clk or negedge reset) begin : debounce_regs
            if (!reset) begin
                cand_q  <= 1'b0;
                stab_q  <= '0;
                level_q <= 1'b0;
            end else begin
                cand_q  <= cand_d;
                stab_q  <= stab_d;
                level_q <= level_d;
            end
        end

        always_ff @(posedge clk or negedge reset) begin : strobe_regs
            if (!reset) begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                cnt_q   <= '0;
            end else begin
                press_q <= press_d;
                rel_q   <= rel_d;
                cnt_q   <= cnt_d;
            end
        end

        assign btn_level[gi]                          = level_q;
        assign press_pulse[gi]                        = press_q;
        assign release_pulse[gi]                      = rel_q;
        assign press_cnt[gi*CNT_WIDTH +: CNT_WIDTH]   = cnt_q;

`ifdef LONG_PRESS_EN
        localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);
        localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              long_q, long_d;

        // Saturation at LONG_CYCLES guarantees a single strobe per hold.
        always_comb begin : hold_next
            hold_d = '0;
            long_d = 1'b0;
            if (level_q) begin
                hold_d = (hold_q == HOLD_MAX) ? hold_q : (hold_q + HOLD_ONE);
                long_d = (hold_q == HOLD_PRE);
            end
        end

        always_ff @(posedge clk or negedge reset) begin : hold_regs
            if (!reset) begin
                hold_q <= '0;
                long_q <= 1'b0;
            end else begin
                hold_q <= hold_d;
                long_q <= long_d;
            end
        end

        assign long_pulse[gi] = long_q;
`else
        assign long_pulse[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_multi_btn.sv
// Randomised and directed bench for debounce_multi_btn; reference model works on a
// per-channel sample history window rather than counters.
module tb_debounce_multi_btn;
    localparam int N    = 4;
    localparam int DEB  = 8;
    localparam int CW   = 4;
    localparam int MOD  = 9;
    localparam int LONG = 20;
    localparam int VW   = 3*N + N*CW + 1 + N;
`ifdef LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif
    // Samples x[k-DEB-2] .. x[k-2] must all agree before a level is accepted.
    localparam int unsigned WIN_MASK = ((32'd1 << (DEB + 1)) - 32'd1) << 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cnt_clr = 1'b0;
    logic [N-1:0]  btn_in = '0;
    logic [N-1:0]  btn_level, press_pulse, release_pulse, long_pulse;
    logic [N*CW-1:0] press_cnt;
    logic          any_press;

    debounce_multi_btn #(
        .N_BTN(N), .DEB_CYCLES(DEB), .CNT_WIDTH(CW), .CNT_MOD(MOD),
        .ACTIVE_LOW(0), .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .cnt_clr(cnt_clr),
        .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .press_cnt(press_cnt), .any_press(any_press), .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned m_hist [N];
    bit          m_level[N], m_press[N], m_rel[N], m_long[N];
    int          m_cnt  [N], m_age[N];

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_hist[c] = 0; m_level[c] = 0; m_press[c] = 0; m_rel[c] = 0;
            m_long[c] = 0; m_cnt[c] = 0; m_age[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < N; c++) begin
            int unsigned win;
            m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
            m_hist[c] = (m_hist[c] << 1) | {31'd0, btn_in[c]};
            win = m_hist[c] & WIN_MASK;
            if (LONG_ON && m_level[c]) begin
                m_age[c]++;
                m_long[c] = (m_age[c] == LONG);
            end
            if (win == WIN_MASK && !m_level[c]) begin
                m_level[c] = 1; m_press[c] = 1; m_age[c] = 0;
            end else if (win == 0 && m_level[c]) begin
                m_level[c] = 0; m_rel[c] = 1;
            end
            if (cnt_clr) m_cnt[c] = 0;
            else if (m_press[c]) m_cnt[c] = (m_cnt[c] + 1) % MOD;
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0]    l, p, r, lg;
        logic [N*CW-1:0] cn;
        for (int c = 0; c < N; c++) begin
            l[c] = m_level[c]; p[c] = m_press[c]; r[c] = m_rel[c]; lg[c] = m_long[c];
            cn[c*CW +: CW] = CW'(m_cnt[c]);
        end
        return {l, p, r, cn, |p, lg};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {btn_level, press_pulse, release_pulse, press_cnt, any_press, long_pulse};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        for (int c = 0; c < N; c++) begin
            if (m_press[c]) $display("t=%0t ch%0d press  cnt=%0d", $time, c, m_cnt[c]);
            if (m_rel[c])   $display("t=%0t ch%0d release", $time, c);
            if (m_long[c])  $display("t=%0t ch%0d long", $time, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; btn_in = 4'b1010; cnt_clr = 1'b0; model_reset();
        repeat (3) step();
        n_checks++;
        if (dut_vec() !== '0) $display("FAIL reset_hold: got %h expected 0", dut_vec());
        else n_pass++;
        btn_in = '0; reset = 1'b1;
        repeat (12) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_single_press();
        int rel_edge = -1;
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL press_seq e%0d: got %h expected %h", e, dut_vec(), exp_vec());
            else n_pass++;
            if (e >= 10 && e <= 12) begin
                n_checks++;
                if (btn_level[0] !== (e >= 11)) $display("FAIL press_latency e%0d: got %b expected %b", e, btn_level[0], e >= 11);
                else n_pass++;
            end
            if (e == 11) begin
                n_checks++;
                if ({press_pulse[0], any_press, press_cnt[3:0]} !== 6'b11_0001)
                    $display("FAIL press_strobe: got %b expected 110001", {press_pulse[0], any_press, press_cnt[3:0]});
                else n_pass++;
            end
        end
        btn_in[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL release_seq e%0d: got %h expected %h", e, dut_vec(), exp_vec());
            else n_pass++;
            if (release_pulse[0] && rel_edge < 0) rel_edge = e;
        end
        n_checks++;
        if (rel_edge != 11) $display("FAIL release_latency: got %0d expected 11", rel_edge);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int np = 0, nr = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            btn_in[1] = (cyc >= 30) ? 1'b1 : (((cyc / 3) % 2) == 0);
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL glitch c%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            else n_pass++;
            if (press_pulse[1]) np++;
            if (release_pulse[1]) nr++;
        end
        n_checks++;
        if (np != 1 || nr != 0 || press_cnt[7:4] !== 4'd1)
            $display("FAIL glitch_summary: got press=%0d rel=%0d cnt=%0d expected 1 0 1", np, nr, press_cnt[7:4]);
        else n_pass++;
        btn_in[1] = 1'b0;
        repeat (14) step();
    endtask

    task automatic test_wrap();
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            btn_in[2] = 1'b1;
            repeat (12) begin
                step();
                n_checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL wrap_press k%0d: got %h expected %h", k, dut_vec(), exp_vec());
                else n_pass++;
            end
            n_checks++;
            if (press_cnt[11:8] !== CW'(k % 9)) $display("FAIL wrap_count k%0d: got %0d expected %0d", k, press_cnt[11:8], k % 9);
            else n_pass++;
            btn_in[2] = 1'b0;
            repeat (12) step();
        end
        n_checks++;
        if ({press_cnt[15:12], press_cnt[7:0]} !== 12'd0)
            $display("FAIL wrap_others: got %h expected 000", {press_cnt[15:12], press_cnt[7:0]});
        else n_pass++;
    endtask

    task automatic test_clr_priority();
        btn_in[1] = 1'b1; btn_in[3] = 1'b1;
        repeat (10) step();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++;
        if ({press_pulse[1], press_pulse[3], press_cnt[7:4], press_cnt[15:12]} !== 10'b11_0000_0000)
            $display("FAIL clr_priority: got %b expected 1100000000",
                     {press_pulse[1], press_pulse[3], press_cnt[7:4], press_cnt[15:12]});
        else n_pass++;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL clr_vec: got %h expected %h", dut_vec(), exp_vec());
        else n_pass++;
        btn_in[1] = 1'b0; btn_in[3] = 1'b0;
        repeat (12) step();
        btn_in[1] = 1'b1;
        repeat (12) step();
        n_checks++;
        if ({press_cnt[7:4], press_cnt[15:12]} !== 8'h10)
            $display("FAIL clr_next_press: got %h expected 10", {press_cnt[7:4], press_cnt[15:12]});
        else n_pass++;
        btn_in[1] = 1'b0;
        repeat (12) step();
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        btn_in[0] = 1'b1;
        repeat (5) step();
        reset = 1'b0; model_reset();
        #1;
        n_checks++;
        if (dut_vec() !== '0) $display("FAIL reset_mid_async: got %h expected 0", dut_vec());
        else n_pass++;
        repeat (3) step();
        reset = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL reset_mid_seq e%0d: got %h expected %h", e, dut_vec(), exp_vec());
            else n_pass++;
            if (btn_level[0] && rise < 0) rise = e;
        end
        n_checks++;
        if (rise != 11) $display("FAIL reset_mid_latency: got %0d expected 11", rise);
        else n_pass++;
        btn_in[0] = 1'b0;
        repeat (14) step();
    endtask

    task automatic test_long();
        int rise = -1, first = -1, n_long = 0, gap;
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 60; e++) begin
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL long_hold e%0d: got %h expected %h", e, dut_vec(), exp_vec());
            else n_pass++;
            if (btn_level[0] && rise < 0) rise = e;
            if (long_pulse[0]) begin
                n_long++;
                if (first < 0) first = e;
            end
        end
        gap = (first < 0) ? -1 : first - rise;
        n_checks++;
        if (n_long != (LONG_ON ? 1 : 0) || gap != (LONG_ON ? LONG : -1))
            $display("FAIL long_strobe: got n=%0d gap=%0d expected n=%0d gap=%0d",
                     n_long, gap, LONG_ON ? 1 : 0, LONG_ON ? LONG : -1);
        else n_pass++;
        btn_in[0] = 1'b0;
        repeat (14) step();
        rise = -1; n_long = 0;
        btn_in[0] = 1'b1;
        for (int e = 1; e <= 50; e++) begin
            if (e == 11) btn_in[0] = 1'b0;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL long_short e%0d: got %h expected %h", e, dut_vec(), exp_vec());
            else n_pass++;
            if (btn_level[0] && rise < 0) rise = e;
            if (long_pulse[0]) n_long++;
        end
        n_checks++;
        if (rise != 11 || n_long != 0) $display("FAIL long_early_release: got rise=%0d n=%0d expected 11 0", rise, n_long);
        else n_pass++;
    endtask

    task automatic test_random();
        int hold_left[N];
        for (int c = 0; c < N; c++) hold_left[c] = $urandom_range(1, 3*DEB);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < N; c++) begin
                hold_left[c]--;
                if (hold_left[c] <= 0) begin
                    btn_in[c] = ~btn_in[c];
                    hold_left[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, DEB + 1)
                                                               : $urandom_range(DEB + 2, 3*DEB);
                end
            end
            cnt_clr = ($urandom_range(0, 39) == 0);
            if (cyc == 700) begin
                reset = 1'b0; model_reset();
            end
            if (cyc == 703) reset = 1'b1;
            step();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random c%0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            else n_pass++;
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap();
        test_clr_priority();
        test_reset_mid();
        test_long();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
